fmul_stream: RTL and testbench

Parametrised, pipelined, multi-lane floating-point multiplier with AXI-stream-style join on two operand streams and full backpressure. It is the next generation of the team's stream multiplier. It adds per-lane IEEE-style rounding and special-case handling, a configurable pipeline depth, a negate mode and a tlast-mismatch error flag. It sits in the vector datapath between operand stream sources and the accumulate/reduce stages.

---
 rtl/fmul_pkg.sv | 29 ++
 rtl/fp_mul_lane.sv | 79 +++++++
 rtl/fmul_stream.sv | 93 +++++++++
 tb/tb_fmul_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared constants, helpers and pipeline-stage control type for the
// multi-lane stream floating-point multiplier.
package fmul_pkg;

   localparam int unsigned FP32_E_WIDTH    = 8;
   localparam int unsigned FP32_FRAC_WIDTH = 23;
   localparam int unsigned FP32_BIT_SIZE   = 1 + FP32_E_WIDTH + FP32_FRAC_WIDTH;
   localparam int unsigned MAX_BIT_SIZE    = 64;

   typedef struct packed {
      logic valid;
      logic tlast;
   } stage_ctl_t;

   function automatic int unsigned bias_of(input int unsigned e_w);
      return (32'd1 << (e_w - 1)) - 32'd1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB only.
   function automatic logic [MAX_BIT_SIZE-1:0] qnan_bits(input int unsigned e_w,
                                                         input int unsigned f_w);
      logic [MAX_BIT_SIZE-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < e_w; i++) r[f_w + i] = 1'b1;
      r[f_w - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_mul_lane.sv
// Combinational single-lane FP multiply: flush-to-zero, round-to-nearest-even,
// overflow to infinity and NaN/infinity/zero special cases.
module fp_mul_lane
   import fmul_pkg::*;
#(
   parameter int unsigned E_WIDTH    = FP32_E_WIDTH,
   parameter int unsigned FRAC_WIDTH = FP32_FRAC_WIDTH
) (
   input  logic [E_WIDTH+FRAC_WIDTH:0] a,
   input  logic [E_WIDTH+FRAC_WIDTH:0] b,
   input  logic                        negate,
   output logic [E_WIDTH+FRAC_WIDTH:0] y
);

   localparam int unsigned W  = 1 + E_WIDTH + FRAC_WIDTH;
   localparam int unsigned M  = FRAC_WIDTH + 1;
   localparam int unsigned XW = E_WIDTH + 2;

   localparam logic signed [XW-1:0] BIAS     = XW'(bias_of(E_WIDTH));
   localparam logic signed [XW-1:0] EXP_TOP  = XW'({E_WIDTH{1'b1}});
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [W-1:0]         QNAN     = W'(qnan_bits(E_WIDTH, FRAC_WIDTH));

   logic                   sa, sb, sign;
   logic [E_WIDTH-1:0]     ea, eb;
   logic [FRAC_WIDTH-1:0]  fa, fb, mant, rmant;
   logic [2*M-1:0]         prod;
   logic                   norm, guard, sticky, rcarry;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic signed [XW-1:0]   exp_r;

   always_comb begin
      y      = '0;
      mant   = '0;
      guard  = 1'b0;
      sticky = 1'b0;

      {sa, ea, fa} = a;
      {sb, eb, fb} = b;
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);
      sign   = sa ^ sb ^ negate;

      prod = (2*M)'({1'b1, fa}) * (2*M)'({1'b1, fb});
      norm = prod[2*M-1];
      if (norm) begin
         mant   = prod[2*M-2 -: FRAC_WIDTH];
         guard  = prod[M-1];
         sticky = |prod[M-2:0];
      end else begin
         mant   = prod[2*M-3 -: FRAC_WIDTH];
         guard  = prod[M-2];
         sticky = |prod[M-3:0];
      end

      // A carry out of the rounded fraction means 1.11..1 rounded to 10.0,
      // so the wrapped-to-zero fraction is already correct after bumping the exponent.
      {rcarry, rmant} = {1'b0, mant} + M'(guard & (sticky | mant[0]));
      exp_r = XW'(ea) + XW'(eb) - BIAS + XW'(norm) + XW'(rcarry);

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         y = QNAN;
      else if (a_inf || b_inf)
         y = {sign, {E_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      else if (a_zero || b_zero)
         y = {sign, {(W-1){1'b0}}};
      else if (exp_r >= EXP_TOP)
         y = {sign, {E_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      else if (exp_r <= EXP_ZERO)
         y = {sign, {(W-1){1'b0}}};
      else
         y = {sign, exp_r[E_WIDTH-1:0], rmant};
   end

endmodule

// File: rtl/fmul_stream.sv
// Multi-lane pipelined FP multiplier joining two operand streams, with a
// globally stalled pipeline, negate mode and sticky tlast-mismatch flag.
module fmul_stream
   import fmul_pkg::*;
#(
   parameter int unsigned PARALLELISM = 4,
   parameter int unsigned E_WIDTH     = FP32_E_WIDTH,
   parameter int unsigned FRAC_WIDTH  = FP32_FRAC_WIDTH,
   parameter int unsigned BIT_SIZE    = 1 + E_WIDTH + FRAC_WIDTH,
   parameter int unsigned LATENCY     = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [BIT_SIZE*PARALLELISM-1:0] a,
   input  logic                            valid_a,
   output logic                            ready_a,
   input  logic                            tlast_a,
   input  logic [BIT_SIZE*PARALLELISM-1:0] b,
   input  logic                            valid_b,
   output logic                            ready_b,
   input  logic                            tlast_b,
   input  logic                            negate,
   output logic [BIT_SIZE*PARALLELISM-1:0] out,
   output logic                            valid,
   input  logic                            ready,
   output logic                            tlast,
   output logic                            tlast_err
);

   if (BIT_SIZE != 1 + E_WIDTH + FRAC_WIDTH) begin : g_bad_bit_size
      $error("fmul_stream: BIT_SIZE must equal 1+E_WIDTH+FRAC_WIDTH");
   end
   if (LATENCY < 1) begin : g_bad_latency
      $error("fmul_stream: LATENCY must be at least 1");
   end

   typedef struct packed {
      stage_ctl_t                             ctl;
      logic [PARALLELISM-1:0][BIT_SIZE-1:0]   lanes;
   } stage_t;

   stage_t                               stg_q [LATENCY];
   stage_t                               stg_in;
   logic [PARALLELISM-1:0][BIT_SIZE-1:0] prod_lanes;
   logic                                 adv, accept;

   assign adv     = !(valid && !ready);
   assign ready_a = valid_b && adv;
   assign ready_b = valid_a && adv;
   assign accept  = valid_a && valid_b && adv;

   for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
      fp_mul_lane #(
         .E_WIDTH    (E_WIDTH),
         .FRAC_WIDTH (FRAC_WIDTH)
      ) u_lane (
         .a      (a[i*BIT_SIZE +: BIT_SIZE]),
         .b      (b[i*BIT_SIZE +: BIT_SIZE]),
         .negate (negate),
         .y      (prod_lanes[i])
      );
   end

   // Negate is folded into the lane sign before the first register, so the
   // stages only need to carry valid, tlast and the finished lane results.
   always_comb begin
      stg_in           = '0;
      stg_in.ctl.valid = accept;
      stg_in.ctl.tlast = tlast_a & tlast_b;
      stg_in.lanes     = prod_lanes;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) stg_q[i] <= '0;
      end else if (adv) begin
         stg_q[0] <= stg_in;
         for (int unsigned i = 1; i < LATENCY; i++) stg_q[i] <= stg_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tlast_err <= 1'b0;
      else if (accept && (tlast_a != tlast_b))
         tlast_err <= 1'b1;
   end

   assign valid = stg_q[LATENCY-1].ctl.valid;
   assign tlast = stg_q[LATENCY-1].ctl.tlast;
   assign out   = stg_q[LATENCY-1].lanes;

endmodule

// File: tb/tb_fmul_stream.sv
// Directed bench for fmul_stream (fp32, 4 lanes, LATENCY=3) with
// hand-computed products and an in-order expected-beat queue.
module tb_fmul_stream;

   localparam int unsigned P  = 4;
   localparam int unsigned BS = 32;
   localparam int unsigned L  = 3;

   // Beat vectors: lane 3 .. lane 0, left to right.
   localparam logic [127:0] A_A = {32'h80000000, 32'h3F800000, 32'h3FC00000, 32'h40000000};
   localparam logic [127:0] A_B = {32'h40000000, 32'h3F800000, 32'h3FC00000, 32'h40400000};
   localparam logic [127:0] A_E = {32'h80000000, 32'h3F800000, 32'h40100000, 32'h40C00000};
   // negate = 1
   localparam logic [127:0] B_A = {32'h3F800000, 32'h7FC00000, 32'h7F800000, 32'h40000000};
   localparam logic [127:0] B_B = {32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40400000};
   localparam logic [127:0] B_E = {32'hBF800000, 32'h7FC00000, 32'h7FC00000, 32'hC0C00000};
   localparam logic [127:0] C_A = {32'hFF800000, 32'h00000001, 32'h00800000, 32'h7F7FFFFF};
   localparam logic [127:0] C_B = {32'h40000000, 32'h40000000, 32'h3F000000, 32'h40000000};
   localparam logic [127:0] C_E = {32'hFF800000, 32'h00000000, 32'h00000000, 32'h7F800000};
   localparam logic [127:0] D_A = {32'hC0000000, 32'h3F800003, 32'h3F800001, 32'h3F800001};
   localparam logic [127:0] D_B = {32'h40400000, 32'h3FC00000, 32'h3FC00000, 32'h3F800001};
   localparam logic [127:0] D_E = {32'hC0C00000, 32'h3FC00004, 32'h3FC00002, 32'h3F800002};
   localparam logic [127:0] E_A = {32'h7F800000, 32'hBF800000, 32'h42000000, 32'h3F800001};
   localparam logic [127:0] E_B = {32'hFF800000, 32'hBF800000, 32'h3E800000, 32'h3FFFFFFE};
   localparam logic [127:0] E_E = {32'hFF800000, 32'h3F800000, 32'h41000000, 32'h40000000};

   typedef struct {
      logic [127:0] d;
      logic         tl;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] a, b, out;
   logic         valid_a, ready_a, tlast_a, valid_b, ready_b, tlast_b;
   logic         negate, valid, ready, tlast, tlast_err;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_push = 0;
   int   n_pop  = 0;
   int   cyc    = 0;
   int   c0, p0;

   fmul_stream #(
      .PARALLELISM (P),
      .E_WIDTH     (8),
      .FRAC_WIDTH  (23),
      .BIT_SIZE    (BS),
      .LATENCY     (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .valid_a   (valid_a),
      .ready_a   (ready_a),
      .tlast_a   (tlast_a),
      .b         (b),
      .valid_b   (valid_b),
      .ready_b   (ready_b),
      .tlast_b   (tlast_b),
      .negate    (negate),
      .out       (out),
      .valid     (valid),
      .ready     (ready),
      .tlast     (tlast),
      .tlast_err (tlast_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp_v);
      end
   endtask

   // Output beat consumed at the next posedge when valid && ready at the negedge.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", 128'(valid), 128'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("lanes", out, mon_e.d);
            check("tlast", 128'(tlast), 128'(mon_e.tl));
            n_pop++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [127:0] av, input logic [127:0] bv, input logic neg,
                       input logic tla, input logic tlb, input logic [127:0] ev,
                       input logic etl, input bit push, input int unsigned b_delay);
      int unsigned waited;
      a = av; b = bv; negate = neg; tlast_a = tla; tlast_b = tlb;
      valid_a = 1'b1;
      valid_b = (b_delay == 0);
      for (int unsigned i = 0; i < b_delay; i++) begin
         @(negedge clk);
         check("skew_ready_a", 128'(ready_a), 128'(0));
         check("skew_ready_b", 128'(ready_b), 128'(1));
         @(posedge clk); #1;
      end
      valid_b = 1'b1;
      waited  = 0;
      @(negedge clk);
      while (!ready_a && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!ready_a) check("accept_timeout", 128'(ready_a), 128'(1));
      else if (push) begin
         exp_q.push_back(exp_t'{ev, etl});
         n_push++;
      end
      @(posedge clk); #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   task automatic drain();
      repeat (L + 3) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; a = '0; b = '0; negate = 1'b0; ready = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0; tlast_a = 1'b0; tlast_b = 1'b0;

      @(negedge clk);
      check("rst_valid", 128'(valid), 128'(0));
      check("rst_tlast", 128'(tlast), 128'(0));
      check("rst_tlast_err", 128'(tlast_err), 128'(0));
      check("rst_out", out, 128'(0));
      valid_b = 1'b1; #1;
      check("rst_ready_a", 128'(ready_a), 128'(1));
      valid_b = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // Latency: visible after the second edge following acceptance.
      send(A_A, A_B, 1'b0, 1'b0, 1'b0, A_E, 1'b0, 1'b1, 0);
      check("lat_edge_n", 128'(valid), 128'(0));
      @(posedge clk); #1;
      check("lat_edge_n1", 128'(valid), 128'(0));
      @(posedge clk); #1;
      check("lat_edge_n2", 128'(valid), 128'(1));
      check("lat_out", out, A_E);
      drain();

      // Back-to-back: negate/specials, overflow/FTZ, rounding.
      c0 = cyc;
      send(B_A, B_B, 1'b1, 1'b0, 1'b0, B_E, 1'b0, 1'b1, 0);
      send(C_A, C_B, 1'b0, 1'b0, 1'b0, C_E, 1'b0, 1'b1, 0);
      send(D_A, D_B, 1'b0, 1'b0, 1'b0, D_E, 1'b0, 1'b1, 0);
      check("b2b_cycles", 128'(cyc - c0), 128'(3));
      drain();

      // Backpressure with a full pipe.
      ready = 1'b0;
      send(A_A, A_B, 1'b0, 1'b0, 1'b0, A_E, 1'b0, 1'b1, 0);
      send(B_A, B_B, 1'b1, 1'b0, 1'b0, B_E, 1'b0, 1'b1, 0);
      send(C_A, C_B, 1'b0, 1'b0, 1'b0, C_E, 1'b0, 1'b1, 0);
      check("bp_full_valid", 128'(valid), 128'(1));
      a = D_A; b = D_B; negate = 1'b0; valid_a = 1'b1; valid_b = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_ready_a", 128'(ready_a), 128'(0));
         check("bp_ready_b", 128'(ready_b), 128'(0));
         check("bp_valid", 128'(valid), 128'(1));
         check("bp_out_hold", out, A_E);
         @(posedge clk); #1;
      end
      ready = 1'b1; #1;
      check("release_ready_a", 128'(ready_a), 128'(1));
      send(D_A, D_B, 1'b0, 1'b0, 1'b0, D_E, 1'b0, 1'b1, 0);
      drain();

      // Join skew: B arrives four cycles after A; includes a rounding-carry lane.
      send(E_A, E_B, 1'b0, 1'b0, 1'b0, E_E, 1'b0, 1'b1, 4);
      drain();

      // tlast mismatch then a matched last beat; error flag stays set.
      send(D_A, D_B, 1'b0, 1'b1, 1'b0, D_E, 1'b0, 1'b1, 0);
      check("tlast_err_set", 128'(tlast_err), 128'(1));
      send(A_A, A_B, 1'b0, 1'b1, 1'b1, A_E, 1'b1, 1'b1, 0);
      drain();
      check("tlast_err_sticky", 128'(tlast_err), 128'(1));

      // Reset with three beats in flight: none may ever appear.
      ready = 1'b0;
      send(B_A, B_B, 1'b1, 1'b0, 1'b0, B_E, 1'b0, 1'b0, 0);
      send(C_A, C_B, 1'b0, 1'b0, 1'b0, C_E, 1'b0, 1'b0, 0);
      send(D_A, D_B, 1'b0, 1'b0, 1'b0, D_E, 1'b0, 1'b0, 0);
      check("inflight_valid", 128'(valid), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", 128'(valid), 128'(0));
      check("midrst_tlast_err", 128'(tlast_err), 128'(0));
      check("midrst_out", out, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0; ready = 1'b1;
      p0 = n_pop;
      repeat (8) @(posedge clk);
      #1;
      check("midrst_no_beats", 128'(n_pop - p0), 128'(0));

      check("pending_beats", 128'(exp_q.size()), 128'(0));
      check("beats_out", 128'(n_pop), 128'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
